// File: rtl/tone_scheduler.sv
// tone_scheduler: one shared square-wave tone divider serving four piano lanes.
// Lanes post note requests. A round-robin arbiter picks a pending lane, the
// divider plays that lane's half-period for a fixed duration, and a silent
// gap follows before the next note.
// Optional build macro TONE_RETRIGGER_EN: a request from the playing lane
// extends the current note instead of queueing a replay.
module tone_scheduler #(
  parameter int unsigned HALF0      = 95556,
  parameter int unsigned HALF1      = 85131,
  parameter int unsigned HALF2      = 75843,
  parameter int unsigned HALF3      = 71586,
  parameter int unsigned DUR_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       enable,
  output logic       tone_out,
  output logic [3:0] grant,
  output logic [1:0] active_lane,
  output logic       busy,
  output logic       note_done
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [31:0] DUR_LAST = 32'(DUR_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  pend;
  logic [3:0]  grant_nx;
  logic [3:0]  req_eff;
  logic [1:0]  last;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        found;
  logic        retrig;
  logic [31:0] half;
  logic [31:0] half_sel;
  logic [31:0] div_cnt;
  logic [31:0] dur_cnt;
  logic [31:0] gap_cnt;

`ifdef TONE_RETRIGGER_EN
  // A request from the lane already playing restarts its duration.
  assign retrig = (state == PLAY) && req[active_lane];
`else
  assign retrig = 1'b0;
`endif

  // A retrigger request is consumed by the note itself, never queued.
  assign req_eff = retrig ? (req & ~(4'b0001 << active_lane)) : req;

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    pick  = last;
    found = 1'b0;
    cand  = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && pend[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Half-period lookup for the lane about to be granted.
  always_comb begin
    half_sel = 32'(HALF0);
    case (pick)
      2'd0: half_sel = 32'(HALF0);
      2'd1: half_sel = 32'(HALF1);
      2'd2: half_sel = 32'(HALF2);
      2'd3: half_sel = 32'(HALF3);
      default: half_sel = 32'(HALF0);
    endcase
  end

  // Next-state and grant decode.
  always_comb begin
    state_nx = state;
    grant_nx = 4'b0000;
    case (state)
      IDLE: if (enable && found) begin
        state_nx = PLAY;
        grant_nx = 4'b0001 << pick;
      end
      // Abort on mute; a retrigger beats the end-of-duration compare.
      PLAY: if (!enable || (!retrig && dur_cnt == DUR_LAST)) state_nx = GAP;
      GAP:  if (gap_cnt == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Pending requests, arbiter pointer, divider, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 4'b0000;
      last        <= 2'd3;
      grant       <= 4'b0000;
      active_lane <= 2'd0;
      tone_out    <= 1'b0;
      note_done   <= 1'b0;
      busy        <= 1'b0;
      half        <= 32'd1;
      div_cnt     <= 32'd0;
      dur_cnt     <= 32'd0;
      gap_cnt     <= 32'd0;
    end else begin
      pend      <= (pend & ~grant_nx) | req_eff;
      grant     <= grant_nx;
      busy      <= (state_nx != IDLE);
      note_done <= 1'b0;
      case (state)
        IDLE: if (state_nx == PLAY) begin
          last        <= pick;
          active_lane <= pick;
          half        <= half_sel;
          div_cnt     <= 32'd0;
          dur_cnt     <= 32'd0;
          tone_out    <= 1'b0;
        end
        PLAY: if (state_nx == GAP) begin
          tone_out  <= 1'b0;
          gap_cnt   <= 32'd0;
          note_done <= enable;  // only a completed note reports done
        end else begin
          if (div_cnt == half - 32'd1) begin
            tone_out <= ~tone_out;
            div_cnt  <= 32'd0;
          end else begin
            div_cnt <= div_cnt + 32'd1;
          end
          dur_cnt <= retrig ? 32'd0 : dur_cnt + 32'd1;
        end
        GAP: begin
          tone_out <= 1'b0;
          gap_cnt  <= gap_cnt + 32'd1;
        end
        default: tone_out <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: note-level reference model compared every cycle,
// plus directed scenarios with hand-computed timing expectations.
module tb_tone_scheduler;

  localparam int DUR = 12;
  localparam int GAPC = 3;
`ifdef TONE_RETRIGGER_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       enable;
  logic       tone_out;
  logic [3:0] grant;
  logic [1:0] active_lane;
  logic       busy;
  logic       note_done;

  int total = 0;
  int bad = 0;

  tone_scheduler #(
    .HALF0(2), .HALF1(3), .HALF2(4), .HALF3(5),
    .DUR_CYCLES(DUR), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .enable(enable),
    .tone_out(tone_out), .grant(grant), .active_lane(active_lane),
    .busy(busy), .note_done(note_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- note-level reference model ----------------
  int         hv[4] = '{2, 3, 4, 5};
  int         m_mode;      // 0 silent/idle, 1 note sounding, 2 gap
  int         m_phase;     // cycles since the note started
  int         m_remain;    // note cycles left, counting the current one
  int         m_gleft;     // gap cycles left, counting the current one
  int         m_last;
  logic [3:0] m_pend;
  logic [1:0] m_lane;
  logic       m_tone;
  logic [3:0] m_grant;
  logic       m_done;

  // Advance the model one clock using the inputs seen at the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_remain = 0; m_gleft = 0; m_last = 3;
      m_pend = 4'b0; m_lane = 2'd0; m_tone = 1'b0; m_grant = 4'b0; m_done = 1'b0;
    end else begin
      logic [3:0] r;
      logic [3:0] keep;
      bit rt, got;
      int lane;
      r = req;
      m_grant = 4'b0;
      m_done = 1'b0;
      rt = RT && (m_mode == 1) && r[m_lane];
      keep = rt ? (r & ~(4'b0001 << m_lane)) : r;
      got = 1'b0;
      lane = 0;
      if (m_mode == 0) begin
        if (enable && m_pend != 4'b0) begin
          for (int k = 1; k <= 4; k++) begin
            if (!got && m_pend[(m_last + k) % 4]) begin
              lane = (m_last + k) % 4;
              got = 1'b1;
            end
          end
          m_grant[lane] = 1'b1;
          m_mode = 1; m_phase = 0; m_remain = DUR;
          m_lane = 2'(lane); m_last = lane;
        end
      end else if (m_mode == 1) begin
        if (!enable) begin
          m_mode = 2; m_gleft = GAPC;
        end else begin
          m_phase++;
          m_remain = rt ? DUR : m_remain - 1;
          if (m_remain == 0) begin
            m_mode = 2; m_gleft = GAPC; m_done = 1'b1;
          end
        end
      end else begin
        m_gleft--;
        if (m_gleft == 0) m_mode = 0;
      end
      m_pend = (m_pend & ~m_grant) | keep;
      m_tone = (m_mode == 1) ? 1'((m_phase / hv[m_lane]) % 2) : 1'b0;
    end
  end

  // Compare every output against the model each cycle, away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_tone", int'(tone_out), int'(m_tone));
      chk("cmp_grant", int'(grant), int'(m_grant));
      chk("cmp_lane", int'(active_lane), int'(m_lane));
      chk("cmp_busy", int'(busy), int'(m_mode != 0));
      chk("cmp_done", int'(note_done), int'(m_done));
    end
  end

  // Event log of grants and completed notes.
  int         cyc = 0;
  int         g_time[$];
  logic [3:0] g_val[$];
  int         d_time[$];
  always @(posedge clk) begin
    #1;
    cyc++;
    if (grant != 4'b0) begin
      g_time.push_back(cyc);
      g_val.push_back(grant);
    end
    if (note_done) d_time.push_back(cyc);
  end

  // ---------------- directed scenarios ----------------
  logic [11:0] pat = 12'b1100_1100_1100;
  int b, d0;

  initial begin
    rst_n = 1'b0; req = 4'b0; enable = 1'b1;
    step(2);
    chk("rst_tone", int'(tone_out), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(note_done), 0);
    chk("rst_lane", int'(active_lane), 0);
    rst_n = 1'b1;
    step(1);

    // Single request: grant two cycles later, tone period 4, gap of 3.
    req = 4'b0001; step(1); req = 4'b0; step(1);
    chk("t1_grant", int'(grant), 1);
    chk("t1_lane", int'(active_lane), 0);
    for (int i = 0; i < 12; i++) begin
      chk("t1_tone", int'(tone_out), int'(pat[i]));
      chk("t1_busy", int'(busy), 1);
      step(1);
    end
    chk("t1_done", int'(note_done), 1);
    chk("t1_tone_gap", int'(tone_out), 0);
    step(1); chk("t1_busy_g1", int'(busy), 1);
    step(1); chk("t1_busy_g2", int'(busy), 1);
    step(1); chk("t1_busy_idle", int'(busy), 0);
    step(3);

    // Round-robin from reset: lanes 0..3, 16 cycles apart.
    rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
    b = g_time.size();
    req = 4'b1111; step(1); req = 4'b0; step(70);
    chk("t2_count", g_time.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      if (g_val.size() > b + i) chk("t2_order", int'(g_val[b + i]), 1 << i);
      if (i > 0 && g_time.size() > b + i)
        chk("t2_spacing", g_time[b + i] - g_time[b + i - 1], 16);
    end
    chk("t2_pend", int'(dut.pend), 0);
    chk("t2_busy", int'(busy), 0);

    // Enable abort at PLAY cycle 5; a muted request waits for enable.
    d0 = d_time.size();
    req = 4'b0100; step(1); req = 4'b0; step(1);
    chk("t3_grant", int'(grant), 4);
    step(5);
    enable = 1'b0; req = 4'b0010; step(1); req = 4'b0;
    chk("t3_tone", int'(tone_out), 0);
    chk("t3_nodone", int'(note_done), 0);
    chk("t3_busy", int'(busy), 1);
    step(2); chk("t3_busy_g2", int'(busy), 1);
    step(1); chk("t3_idle", int'(busy), 0);
    chk("t3_done_cnt", d_time.size() - d0, 0);
    b = g_time.size();
    step(10);
    chk("t3_blocked", g_time.size() - b, 0);
    enable = 1'b1; step(1);
    chk("t3_grant2", int'(grant), 2);
    step(20);

    // Async reset mid-note with lanes 1 and 3 pending.
    req = 4'b0001; step(1); req = 4'b0; step(1);
    chk("t4_grant", int'(grant), 1);
    req = 4'b1010; step(1); req = 4'b0; step(2);
    chk("t4_tone_hi", int'(tone_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_tone", int'(tone_out), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_grant0", int'(grant), 0);
    chk("t4_pend", int'(dut.pend), 0);
    @(negedge clk) rst_n = 1'b1;
    b = g_time.size();
    step(30);
    chk("t4_nogrant", g_time.size() - b, 0);

`ifndef TONE_RETRIGGER_EN
    // Request held across its own grant: lane 0 replays after the gap.
    b = g_time.size(); d0 = d_time.size();
    req = 4'b0001; step(2); req = 4'b0; step(40);
    chk("t5_count", g_time.size() - b, 2);
    if (g_time.size() >= b + 2) begin
      chk("t5_lane_a", int'(g_val[b]), 1);
      chk("t5_lane_b", int'(g_val[b + 1]), 1);
      chk("t5_spacing", g_time[b + 1] - g_time[b], 16);
    end
    chk("t5_dones", d_time.size() - d0, 2);
`else
    // Retrigger in the 8th PLAY cycle: one note of 20 cycles.
    b = g_time.size(); d0 = d_time.size();
    req = 4'b0001; step(1); req = 4'b0; step(1);
    chk("t6_grant", int'(grant), 1);
    step(7);
    req = 4'b0001; step(1); req = 4'b0;
    step(11);
    chk("t6_not_yet", int'(note_done), 0);
    step(1);
    chk("t6_done", int'(note_done), 1);
    step(8);
    chk("t6_grants", g_time.size() - b, 1);
    chk("t6_dones", d_time.size() - d0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
